pong_game_ctrl: RTL and testbench

Game sequencer for Pong. It owns match state: idle, serve countdown, rally, point-scored hold and game over. It watches the ball position once per frame, detects goals, keeps both scores, and drives the ball datapath through a recentre pulse (ball_load), a motion enable (ball_run) and a serve direction. It sits between the VGA timing/frame-tick logic and the ball and score-display blocks.

---
 rtl/pong_game_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Pong match sequencer. Tracks match state (idle, serve
//                countdown, rally, point hold, game over), detects goals from
//                the ball x position once per frame, keeps both scores and
//                drives the ball datapath (recentre pulse, run enable, serve
//                direction).
//  Ports       : clk        - pixel clock
//                reset      - asynchronous, active-high
//                frame_tick - one-clk pulse per frame
//                start      - one-clk start button pulse
//                pause      - level, freezes play while high
//                ball_x     - ball centre x, valid while frame_tick is high
//                ball_run   - ball datapath motion enable
//                ball_load  - one-clk recentre pulse
//                serve_dir  - 0 toward left player, 1 toward right player
//                score_p1   - left player score
//                score_p2   - right player score
//                game_over  - high in the game-over state
//                winner     - 0 player 1, 1 player 2 (valid with game_over)
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_HOLD  = 90,
    parameter int LEFT_GOAL   = 20,
    parameter int RIGHT_GOAL  = 619
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] ball_x,
    output logic       ball_run,
    output logic       ball_load,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       winner
);

    localparam int CNT_MAX = (SERVE_DELAY > SCORE_HOLD) ? SERVE_DELAY : SCORE_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] c_serve_last = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(SCORE_HOLD - 1);
    localparam logic [3:0]       c_win        = 4'(WIN_SCORE);

    localparam logic [2:0] c_idle       = 3'd0;
    localparam logic [2:0] c_serve_wait = 3'd1;
    localparam logic [2:0] c_play       = 3'd2;
    localparam logic [2:0] c_scored     = 3'd3;
    localparam logic [2:0] c_game_over  = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // A tick only advances the game when play is not frozen.
    logic w_tick;
    logic w_hit_left;
    logic w_hit_right;
    logic w_match_won;

    assign w_tick      = frame_tick & ~pause;
    assign w_hit_left  = (ball_x <= 10'(LEFT_GOAL));
    assign w_hit_right = (ball_x >= 10'(RIGHT_GOAL));
    assign w_match_won = (score_p1 == c_win) || (score_p2 == c_win);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            ball_run  <= 1'b0;
            ball_load <= 1'b0;
            serve_dir <= 1'b1;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            // ball_load is a single-cycle pulse: it falls back every cycle.
            ball_load <= 1'b0;
            case (r_state)
                c_idle, c_game_over: begin
                    ball_run <= 1'b0;
                    // start beats a coincident frame_tick; the tick is dropped.
                    if (start) begin
                        score_p1  <= 4'd0;
                        score_p2  <= 4'd0;
                        game_over <= 1'b0;
                        winner    <= 1'b0;
                        r_cnt     <= '0;
                        ball_load <= 1'b1;
                        r_state   <= c_serve_wait;
                    end
                end
                c_serve_wait: begin
                    ball_run <= 1'b0;
                    if (w_tick) begin
                        if (r_cnt == c_serve_last) begin
                            r_cnt    <= '0;
                            ball_run <= 1'b1;
                            r_state  <= c_play;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_play: begin
                    ball_run <= ~pause;
                    if (w_tick) begin
                        // Left goal is checked first so an overlapping
                        // window always favours player 2.
                        if (w_hit_left) begin
                            if (score_p2 != c_win) score_p2 <= score_p2 + 4'd1;
                            serve_dir <= 1'b0;
                            ball_run  <= 1'b0;
                            r_state   <= c_scored;
                        end else if (w_hit_right) begin
                            if (score_p1 != c_win) score_p1 <= score_p1 + 4'd1;
                            serve_dir <= 1'b1;
                            ball_run  <= 1'b0;
                            r_state   <= c_scored;
                        end
                    end
                end
                c_scored: begin
                    ball_run <= 1'b0;
                    if (w_tick) begin
                        if (r_cnt == c_hold_last) begin
                            r_cnt <= '0;
                            if (w_match_won) begin
                                game_over <= 1'b1;
                                winner    <= (score_p2 == c_win);
                                r_state   <= c_game_over;
                            end else begin
                                ball_load <= 1'b1;
                                r_state   <= c_serve_wait;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    ball_run <= 1'b0;
                    r_state  <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_game_ctrl
//  Description : Directed self-checking bench for pong_game_ctrl with
//                SERVE_DELAY=3, SCORE_HOLD=2, WIN_SCORE=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic [9:0] ball_x;
    logic       ball_run;
    logic       ball_load;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_over;
    logic       winner;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl #(
        .WIN_SCORE  (2),
        .SERVE_DELAY(3),
        .SCORE_HOLD (2),
        .LEFT_GOAL  (20),
        .RIGHT_GOAL (619)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .pause     (pause),
        .ball_x    (ball_x),
        .ball_run  (ball_run),
        .ball_load (ball_load),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .game_over (game_over),
        .winner    (winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Each stimulus pulse spans one posedge; outputs are sampled at the
    // following negedge.
    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; ball_x = 10'd320;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (ball_run !== 1'b0)  begin bad++; $display("FAIL rst_run: got %b want 0", ball_run); end
        total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL rst_load: got %b want 0", ball_load); end
        total++; if (serve_dir !== 1'b1) begin bad++; $display("FAIL rst_dir: got %b want 1", serve_dir); end
        total++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0) begin bad++; $display("FAIL rst_score: got %0d/%0d want 0/0", score_p1, score_p2); end
        total++; if (game_over !== 1'b0 || winner !== 1'b0) begin bad++; $display("FAIL rst_go: got %b/%b want 0/0", game_over, winner); end
    endtask

    task automatic test_serve();
        tick();  // ignored in IDLE
        total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL idle_tick_load: got %b want 0", ball_load); end
        pulse_start();
        total++; if (ball_load !== 1'b1) begin bad++; $display("FAIL start_load: got %b want 1", ball_load); end
        @(negedge clk);
        total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL load_width: got %b want 0", ball_load); end
        ticks(2);
        total++; if (ball_run !== 1'b0) begin bad++; $display("FAIL serve_early: got %b want 0", ball_run); end
        tick();
        total++; if (ball_run !== 1'b1) begin bad++; $display("FAIL serve_run: got %b want 1", ball_run); end
        total++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0) begin bad++; $display("FAIL serve_score: got %0d/%0d want 0/0", score_p1, score_p2); end
    endtask

    task automatic test_left_goal();
        ball_x = 10'd20;
        tick();
        ball_x = 10'd320;
        total++; if (score_p2 !== 4'd1) begin bad++; $display("FAIL lg_p2: got %0d want 1", score_p2); end
        total++; if (serve_dir !== 1'b0) begin bad++; $display("FAIL lg_dir: got %b want 0", serve_dir); end
        total++; if (ball_run !== 1'b0) begin bad++; $display("FAIL lg_run: got %b want 0", ball_run); end
        tick();
        total++; if (ball_load !== 1'b0) begin bad++; $display("FAIL lg_hold1: got %b want 0", ball_load); end
        tick();
        total++; if (ball_load !== 1'b1 || ball_run !== 1'b0) begin bad++; $display("FAIL lg_reload: got load=%b run=%b want 1/0", ball_load, ball_run); end
        ticks(2);
        total++; if (ball_run !== 1'b0) begin bad++; $display("FAIL lg_serve_early: got %b want 0", ball_run); end
        tick();
        total++; if (ball_run !== 1'b1) begin bad++; $display("FAIL lg_serve: got %b want 1", ball_run); end
    endtask

    task automatic test_right_win();
        ball_x = 10'd619;
        tick();
        ball_x = 10'd320;
        total++; if (score_p1 !== 4'd1 || serve_dir !== 1'b1) begin bad++; $display("FAIL rg1: got p1=%0d dir=%b want 1/1", score_p1, serve_dir); end
        ticks(2);
        total++; if (ball_load !== 1'b1) begin bad++; $display("FAIL rg1_load: got %b want 1", ball_load); end
        ticks(3);
        ball_x = 10'd619;
        tick();
        ball_x = 10'd320;
        total++; if (score_p1 !== 4'd2) begin bad++; $display("FAIL rg2: got %0d want 2", score_p1); end
        tick();
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL go_early: got %b want 0", game_over); end
        tick();
        total++; if (game_over !== 1'b1 || winner !== 1'b0) begin bad++; $display("FAIL go: got %b/%b want 1/0", game_over, winner); end
        total++; if (ball_run !== 1'b0 || ball_load !== 1'b0) begin bad++; $display("FAIL go_ball: got run=%b load=%b want 0/0", ball_run, ball_load); end
        ticks(2);
        total++; if (score_p1 !== 4'd2 || score_p2 !== 4'd1) begin bad++; $display("FAIL go_hold: got %0d/%0d want 2/1", score_p1, score_p2); end
        pulse_start();
        total++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || game_over !== 1'b0) begin bad++; $display("FAIL restart: got %0d/%0d go=%b want 0/0/0", score_p1, score_p2, game_over); end
        total++; if (ball_load !== 1'b1) begin bad++; $display("FAIL restart_load: got %b want 1", ball_load); end
        ticks(3);
        total++; if (ball_run !== 1'b1) begin bad++; $display("FAIL restart_serve: got %b want 1", ball_run); end
    endtask

    task automatic test_pause();
        @(negedge clk); pause = 1'b1; ball_x = 10'd10;
        @(negedge clk);
        total++; if (ball_run !== 1'b0) begin bad++; $display("FAIL pause_run: got %b want 0", ball_run); end
        ticks(5);
        total++; if (score_p2 !== 4'd0 || ball_run !== 1'b0) begin bad++; $display("FAIL pause_hold: got p2=%0d run=%b want 0/0", score_p2, ball_run); end
        @(negedge clk); pause = 1'b0;
        @(negedge clk);
        total++; if (ball_run !== 1'b1) begin bad++; $display("FAIL unpause_run: got %b want 1", ball_run); end
        tick();
        ball_x = 10'd320;
        total++; if (score_p2 !== 4'd1 || ball_run !== 1'b0) begin bad++; $display("FAIL unpause_goal: got p2=%0d run=%b want 1/0", score_p2, ball_run); end
    endtask

    task automatic test_start_in_play();
        ticks(2);
        ticks(3);
        total++; if (ball_run !== 1'b1) begin bad++; $display("FAIL sp_serve: got %b want 1", ball_run); end
        pulse_start();
        total++; if (ball_load !== 1'b0 || ball_run !== 1'b1 || score_p2 !== 4'd1) begin bad++; $display("FAIL sp_ignored: got load=%b run=%b p2=%0d want 0/1/1", ball_load, ball_run, score_p2); end
        ball_x = 10'd619;
        tick();
        ball_x = 10'd320;
        total++; if (score_p1 !== 4'd1) begin bad++; $display("FAIL sp_goal: got %0d want 1", score_p1); end
    endtask

    task automatic test_async_reset();
        tick();  // now mid-SCORED, scores 1/1
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || serve_dir !== 1'b1) begin bad++; $display("FAIL arst: got %0d/%0d dir=%b want 0/0/1", score_p1, score_p2, serve_dir); end
        total++; if (ball_run !== 1'b0 || ball_load !== 1'b0 || game_over !== 1'b0 || winner !== 1'b0) begin bad++; $display("FAIL arst_ctl: got run=%b load=%b go=%b w=%b want 0", ball_run, ball_load, game_over, winner); end
        @(negedge clk); reset = 1'b0;
        ticks(3);
        total++; if (ball_run !== 1'b0 || ball_load !== 1'b0) begin bad++; $display("FAIL arst_idle: got run=%b load=%b want 0/0", ball_run, ball_load); end
    endtask

    task automatic test_idle_start_tick();
        @(negedge clk); start = 1'b1; frame_tick = 1'b1;
        @(negedge clk); start = 1'b0; frame_tick = 1'b0;
        total++; if (ball_load !== 1'b1) begin bad++; $display("FAIL st_load: got %b want 1", ball_load); end
        ticks(2);
        total++; if (ball_run !== 1'b0) begin bad++; $display("FAIL st_early: got %b want 0", ball_run); end
        tick();
        total++; if (ball_run !== 1'b1) begin bad++; $display("FAIL st_serve: got %b want 1", ball_run); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_left_goal();
        test_right_win();
        test_pause();
        test_start_in_play();
        test_async_reset();
        test_idle_start_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
